spi_controller_multi: RTL and testbench
=======================================

SPI_CONTROLLER_MULTI -- requirements
Module: spi_controller_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning SPI word width in bits, legal range 4..32.
REQ-002 SHALL have parameter NUM_CS, default 4, meaning number of chip selects, legal range 1..16.
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider field.
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 clk_div  in  DIV_W  half-period of spi_clk is clk_div+1 cycles.
REQ-007 cpol  in  1  idle level of spi_clk.
REQ-008 cpha  in  1  0: sample on first edge, 1: sample on second edge.
REQ-009 lpbk  in  1  internal loopback request.
REQ-010 tx_data  in  DATA_W  word to shift out, MSB first.
REQ-011 tx_cs_sel  in  $clog2(NUM_CS) (min 1)  target chip select.
REQ-012 tx_last  in  1  1: release CS after this word; 0: keep CS asserted for the next word.
REQ-013 tx_valid / tx_ready  in / out  1  word handshake; transfer on both high.
REQ-014 rx_data  out  DATA_W  word captured from poci.
REQ-015 rx_valid  out  1  one-cycle pulse, rx_data valid; no backpressure.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 poci  in  1; pico  out  1; spi_clk  out  1; cs_b  out  NUM_CS, active-low.

Function
REQ-018 States SHALL be IDLE, SETUP, SHIFT, WAIT, HOLD.
REQ-019 tx_ready SHALL be 1 only in IDLE and WAIT.
REQ-020 In IDLE, an accepted word SHALL latch tx_data, tx_cs_sel, tx_last, clk_div, cpol and cpha, drive cs_b[sel] low, and enter SETUP.
REQ-021 SETUP SHALL last one half-period, then enter SHIFT; with cpha=0, pico SHALL present the MSB from entry into SETUP.
REQ-022 SHIFT SHALL generate exactly 2*DATA_W spi_clk edges, each one half-period apart; sample and shift edges SHALL follow cpol/cpha (SPI modes 0-3).
REQ-023 On the last SHIFT edge, rx_data SHALL update and rx_valid SHALL pulse in the same cycle.
REQ-024 On leaving SHIFT, spi_clk SHALL be at cpol; the next state SHALL be HOLD if latched tx_last=1, else WAIT.
REQ-025 WAIT SHALL keep the same cs_b asserted; an accepted word SHALL enter SHIFT directly; its tx_cs_sel SHALL be ignored; clk_div/cpol/cpha SHALL be re-latched.
REQ-026 HOLD SHALL last one half-period with CS still asserted, then deassert all cs_b and return to IDLE.
REQ-027 tx_cs_sel >= NUM_CS SHALL complete the transfer with all cs_b high, and rx_data SHALL still be produced.
REQ-028 clk_div=0 SHALL give spi_clk = S_AXI_ACLK/2; clk_div changes mid-word SHALL have no effect.
REQ-029 At most one cs_b bit SHALL be low at any time.

Reset
REQ-030 While S_AXI_ARESETN=0, outputs SHALL be: cs_b all 1, spi_clk=cpol input, pico=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, state=IDLE.
REQ-031 Reset mid-transfer SHALL abort immediately with no rx_valid; tx_ready SHALL rise in the first cycle after release.

Configuration
REQ-032 With SPI_CTRL_LOOPBACK_EN defined, lpbk=1 SHALL sample the internal pico instead of poci, and cs_b SHALL stay all 1 during that transfer.
REQ-033 Without SPI_CTRL_LOOPBACK_EN, lpbk SHALL be ignored and no loopback logic SHALL be synthesised.

Structure
REQ-034 Package spi_ctrl_pkg SHALL hold the state enum, mode encoding (cpol/cpha pair) and DATA_W limits.
REQ-035 Sub-module spi_clk_gen SHALL implement the half-period counter and edge strobes; the FSM and shift registers SHALL stay in the top module.

Verification
REQ-036 Mode 0, DATA_W=8, clk_div=1, tx_data=0xA5, poci driven by a 0x3C slave model, tx_last=1 -> 8 rising spi_clk edges, each half-period 2 cycles; slave receives 0xA5; rx_data=0x3C with a single rx_valid pulse; cs_b returns to all-1.
REQ-037 Modes 1, 2 and 3, each with 0x81 sent -> slave model captures 0x81 in every mode; spi_clk idles at cpol.
REQ-038 Three words with tx_last=0,0,1 to cs 2 -> cs_b[2] stays low continuously across all three words; 3 rx_valid pulses; no SETUP between words.
REQ-039 Reset asserted at bit 4 of a word -> cs_b all 1 and no rx_valid; a following 0x55 transfer completes correctly.
REQ-040 SPI_CTRL_LOOPBACK_EN defined, lpbk=1, tx_data=0x5A -> rx_data=0x5A with cs_b all 1 throughout.
REQ-041 tx_cs_sel=NUM_CS -> busy pulses for the word duration and cs_b stays all 1.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the multi-chip-select SPI controller: FSM states, SPI mode encoding
// and word-width limits.
package spi_ctrl_pkg;

    localparam int unsigned DataWMin = 4;
    localparam int unsigned DataWMax = 32;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StWait,
        StHold
    } state_e;

    // {cpol, cpha}
    typedef enum logic [1:0] {
        Mode0 = 2'b00,
        Mode1 = 2'b01,
        Mode2 = 2'b10,
        Mode3 = 2'b11
    } spi_mode_e;

    function automatic logic mode_cpha(spi_mode_e mode);
        logic [1:0] bits;
        bits = mode;
        return bits[0];
    endfunction

    // Edges are numbered from 0; even indices are leading edges.
    function automatic logic is_sample_edge(spi_mode_e mode, logic edge_odd);
        return edge_odd == mode_cpha(mode);
    endfunction

endpackage

// File: rtl/spi_controller_multi_if.sv
// Word stream between a host and spi_controller_multi: tx handshake plus rx pulse.
interface spi_controller_multi_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CS_W   = 2
);
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   tx_cs_sel;
    logic              tx_last;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (
        output tx_data, tx_cs_sel, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_cs_sel, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period counter for the SPI clock; strobes half_tick every div+1 cycles while run is high.
module spi_clk_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             half_tick
);

    logic [DIV_W-1:0] cnt_q;

    assign half_tick = run && (cnt_q == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || half_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller_multi.sv
// SPI master with NUM_CS chip selects, modes 0-3 and multi-word CS hold.
// Optional internal loopback is built only when SPI_CTRL_LOOPBACK_EN is defined.
module spi_controller_multi
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lpbk,
    spi_controller_multi_if.slave bus,
    input  logic                  poci,
    output logic                  pico,
    output logic                  spi_clk,
    output logic [NUM_CS-1:0]     cs_b,
    output logic                  busy
);

    localparam int unsigned EdgeW = $clog2(2 * DATA_W);
    localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

    if (DATA_W < DataWMin || DATA_W > DataWMax) begin : gen_bad_data_w
        $error("DATA_W out of range");
    end

    state_e            state_q;
    spi_mode_e         mode_q;
    logic [DIV_W-1:0]  div_q;
    logic              last_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              pico_q;
    logic              sclk_q;
    logic [NUM_CS-1:0] cs_q;
    logic [EdgeW-1:0]  edge_q;

    logic              accept;
    logic              run;
    logic              half_tick;
    logic              rx_bit;
    logic              sample_edge;
    logic              shift_edge;
    logic              last_edge;
    logic [DATA_W-1:0] rx_next;
    logic [NUM_CS-1:0] cs_sel_b;

    assign bus.tx_ready = S_AXI_ARESETN && (state_q == StIdle || state_q == StWait);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign accept       = bus.tx_valid && bus.tx_ready;
    assign busy         = (state_q != StIdle);
    assign run          = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    assign pico         = pico_q;
    assign cs_b         = cs_q;
    // While idle the clock pin tracks the cpol input so the line idles correctly.
    assign spi_clk      = (state_q == StIdle) ? cpol : sclk_q;

`ifdef SPI_CTRL_LOOPBACK_EN
    logic lpbk_q;
    assign rx_bit = lpbk_q ? pico_q : poci;
`else
    logic unused_lpbk;
    assign unused_lpbk = lpbk;
    assign rx_bit      = poci;
`endif

    assign last_edge   = (edge_q == LastEdge);
    assign sample_edge = is_sample_edge(mode_q, edge_q[0]);
    assign shift_edge  = !sample_edge && !last_edge;
    assign rx_next     = sample_edge ? {rx_sr_q[DATA_W-2:0], rx_bit} : rx_sr_q;

    // Out-of-range selects match no bit, leaving every chip select high.
    always_comb begin
        cs_sel_b = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(bus.tx_cs_sel) == i) begin
                cs_sel_b[i] = 1'b0;
            end
        end
`ifdef SPI_CTRL_LOOPBACK_EN
        if (lpbk) begin
            cs_sel_b = '1;
        end
`endif
    end

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .run      (run),
        .div      (div_q),
        .half_tick(half_tick)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= StIdle;
            mode_q     <= Mode0;
            div_q      <= '0;
            last_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            pico_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= '1;
            edge_q     <= '0;
`ifdef SPI_CTRL_LOOPBACK_EN
            lpbk_q     <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            // With cpha=0 the MSB goes out now; with cpha=1 it leaves on the first edge.
            if (accept) begin
                mode_q  <= spi_mode_e'({cpol, cpha});
                div_q   <= clk_div;
                last_q  <= bus.tx_last;
                sclk_q  <= cpol;
                pico_q  <= bus.tx_data[DATA_W-1];
                tx_sr_q <= cpha ? bus.tx_data : {bus.tx_data[DATA_W-2:0], 1'b0};
                edge_q  <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cs_q    <= cs_sel_b;
`ifdef SPI_CTRL_LOOPBACK_EN
                        lpbk_q  <= lpbk;
`endif
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (half_tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (half_tick) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        if (sample_edge) begin
                            rx_sr_q <= rx_next;
                        end
                        if (shift_edge) begin
                            pico_q  <= tx_sr_q[DATA_W-1];
                            tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                        if (last_edge) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            edge_q     <= '0;
                            state_q    <= last_q ? StHold : StWait;
                        end
                    end
                end
                StWait: begin
                    if (accept) begin
                        state_q <= StShift;
                    end
                end
                StHold: begin
                    if (half_tick) begin
                        cs_q    <= '1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller_multi.sv
// Self-checking bench for spi_controller_multi: SPI slave model, rx scoreboard and slave scoreboard.
module tb_spi_controller_multi;
    import spi_ctrl_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCS = 3;
    localparam int unsigned DVW = 8;
    localparam int unsigned CSW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DVW-1:0] clk_div = 8'd1;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           lpbk = 1'b0;
    logic           poci = 1'b1;
    logic           pico;
    logic           spi_clk;
    logic [NCS-1:0] cs_b;
    logic           busy;

    spi_controller_multi_if #(.DATA_W(DW), .CS_W(CSW)) bus ();

    spi_controller_multi #(
        .DATA_W(DW),
        .NUM_CS(NCS),
        .DIV_W (DVW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .clk_div      (clk_div),
        .cpol         (cpol),
        .cpha         (cpha),
        .lpbk         (lpbk),
        .bus          (bus),
        .poci         (poci),
        .pico         (pico),
        .spi_clk      (spi_clk),
        .cs_b         (cs_b),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] rx_exp[$];
    logic [7:0] slave_exp[$];

    // Slave model: reacts to spi_clk edges like a real SPI device.
    logic       cs_act;
    logic       s_cs_prev = 1'b0;
    logic       s_clk_prev = 1'b0;
    logic [7:0] s_resp = 8'h00;
    logic [7:0] s_sr = 8'h00;
    logic [7:0] s_in = 8'h00;
    int         s_bits = 0;
    bit         s_reload = 1'b0;

    assign cs_act = ~(&cs_b);

    always @(spi_clk or cs_act) begin
        if (cs_act && !s_cs_prev) begin
            s_bits   = 0;
            s_reload = 1'b0;
            s_sr     = s_resp;
            if (!cpha) begin
                poci = s_sr[7];
                s_sr = s_sr << 1;
            end
        end else if (!cs_act && s_cs_prev) begin
            poci = 1'b1;
        end else if (cs_act && (spi_clk !== s_clk_prev)) begin
            if ((spi_clk != cpol) ^ cpha) begin
                s_in = {s_in[6:0], pico};
                s_bits++;
                if (s_bits == 8) begin
                    s_bits   = 0;
                    s_reload = 1'b1;
                    if (slave_exp.size() == 0) check_val("slave_extra", 1, 0);
                    else check_val("slave_word", s_in, slave_exp.pop_front());
                end
            end else begin
                if (s_reload) begin
                    s_reload = 1'b0;
                    s_sr     = s_resp;
                end
                poci = s_sr[7];
                s_sr = s_sr << 1;
            end
        end
        s_cs_prev  = cs_act;
        s_clk_prev = spi_clk;
    end

    // Monitor: rx scoreboard plus free-running counters the stimulus snapshots.
    int   cyc = 0;
    int   rx_cnt = 0;
    int   cs_multi_cnt = 0;
    int   cs_low_cnt = 0;
    int   cs2_high_cnt = 0;
    int   setup_cnt = 0;
    int   busy_cnt = 0;
    int   lead_cnt = 0;
    int   hp_meas = 0;
    int   hp_bad = 0;
    int   hp_exp = 2;
    int   last_edge = -1;
    logic m_clk_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                if (rx_exp.size() == 0) check_val("rx_extra", 1, 0);
                else check_val("rx_data", bus.rx_data, rx_exp.pop_front());
            end
            if ($countones(~cs_b) > 1) cs_multi_cnt++;
            if (cs_act) cs_low_cnt++;
            if (cs_b[2]) cs2_high_cnt++;
            if (dut.state_q == StSetup) setup_cnt++;
            if (busy) busy_cnt++;
            if (busy && (spi_clk != m_clk_prev)) begin
                if (spi_clk != cpol) lead_cnt++;
                if (last_edge >= 0 && hp_exp != 0) begin
                    hp_meas++;
                    if (cyc - last_edge != hp_exp) hp_bad++;
                end
                last_edge = cyc;
            end
            if (!busy) last_edge = -1;
        end else begin
            last_edge = -1;
        end
        m_clk_prev = spi_clk;
    end

    task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic last,
                        input logic [7:0] rx_e, input bit to_rx, input bit to_slave);
        int n = 0;
        @(negedge clk);
        bus.tx_data   = d;
        bus.tx_cs_sel = sel;
        bus.tx_last   = last;
        bus.tx_valid  = 1'b1;
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_val("ready_timeout", 0, 1);
        if (to_rx) rx_exp.push_back(rx_e);
        if (to_slave) slave_exp.push_back(d);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_rx(input int target);
        int n = 0;
        while (rx_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("rx_timeout", 0, 1);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_cs_b"}, cs_b, 3'b111);
        check_val({tag, "_spi_clk"}, spi_clk, cpol);
        check_val({tag, "_pico"}, pico, 0);
        check_val({tag, "_tx_ready"}, bus.tx_ready, 0);
        check_val({tag, "_rx_valid"}, bus.rx_valid, 0);
        check_val({tag, "_rx_data"}, bus.rx_data, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_state"}, dut.state_q, StIdle);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, l0, hm0, hb0, c0, r0, s0, c20, n;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.tx_cs_sel = '0;
        bus.tx_last   = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_rst", bus.tx_ready, 1);

        // Mode 0, clk_div=1, 0xA5 out, slave answers 0x3C.
        s_resp = 8'h3C;
        hp_exp = 2;
        b0 = busy_cnt; l0 = lead_cnt; hm0 = hp_meas; hb0 = hp_bad;
        send(8'hA5, 2'd0, 1'b1, 8'h3C, 1, 1);
        wait_idle();
        check_val("m0_rises", lead_cnt - l0, 8);
        check_val("m0_hp_meas", hp_meas - hm0, 15);
        check_val("m0_hp_bad", hp_bad - hb0, 0);
        check_val("m0_busy_cycles", busy_cnt - b0, 36);
        check_val("m0_cs_idle", cs_b, 3'b111);
        check_val("m0_clk_idle", spi_clk, 0);

        // Modes 1..3 with 0x81.
        for (int m = 1; m < 4; m++) begin
            @(negedge clk);
            cpol   = m[1];
            cpha   = m[0];
            s_resp = 8'h7E;
            l0 = lead_cnt; hb0 = hp_bad;
            send(8'h81, 2'd1, 1'b1, 8'h7E, 1, 1);
            wait_idle();
            check_val("mode_leads", lead_cnt - l0, 8);
            check_val("mode_hp_bad", hp_bad - hb0, 0);
            check_val("mode_clk_idle", spi_clk, cpol);
        end

        // Three-word burst to cs 2 in mode 0.
        @(negedge clk);
        cpol   = 1'b0;
        cpha   = 1'b0;
        hp_exp = 0;
        s_resp = 8'hC3;
        r0 = rx_cnt;
        send(8'h11, 2'd2, 1'b0, 8'hC3, 1, 1);
        c20 = cs2_high_cnt;
        wait_rx(r0 + 1);
        s0 = setup_cnt;
        send(8'h22, 2'd0, 1'b0, 8'hC3, 1, 1);
        send(8'h33, 2'd1, 1'b1, 8'hC3, 1, 1);
        wait_rx(r0 + 3);
        check_val("burst_cs2_gap", cs2_high_cnt - c20, 0);
        check_val("burst_no_setup", setup_cnt - s0, 0);
        wait_idle();
        check_val("burst_rx_pulses", rx_cnt - r0, 3);
        check_val("burst_cs_idle", cs_b, 3'b111);

        // Reset at bit 4 of a word, then a clean 0x55 transfer.
        hp_exp = 2;
        s_resp = 8'h99;
        r0 = rx_cnt;
        l0 = lead_cnt;
        send(8'hF0, 2'd1, 1'b1, 8'h00, 0, 0);
        n = 0;
        while (lead_cnt < l0 + 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_val("bit4_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        repeat (2) @(negedge clk);
        check_reset("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_ready", bus.tx_ready, 1);
        check_val("abort_no_rx", rx_cnt - r0, 0);
        s_resp = 8'hA6;
        send(8'h55, 2'd1, 1'b1, 8'hA6, 1, 1);
        wait_idle();
        check_val("post_abort_rx", rx_cnt - r0, 1);

        // clk_div=0 gives a one-cycle half-period; a mid-word change is ignored.
        @(negedge clk);
        clk_div = 8'd0;
        hp_exp  = 1;
        s_resp  = 8'h5C;
        b0 = busy_cnt; hm0 = hp_meas; hb0 = hp_bad;
        send(8'h3A, 2'd0, 1'b1, 8'h5C, 1, 1);
        clk_div = 8'd3;
        wait_idle();
        check_val("div0_hp_meas", hp_meas - hm0, 15);
        check_val("div0_hp_bad", hp_bad - hb0, 0);
        check_val("div0_busy_cycles", busy_cnt - b0, 18);

        // Out-of-range chip select: no CS, rx still produced from the idle-high line.
        @(negedge clk);
        clk_div = 8'd1;
        hp_exp  = 2;
        b0 = busy_cnt; c0 = cs_low_cnt;
        send(8'hE7, 2'd3, 1'b1, 8'hFF, 1, 0);
        wait_idle();
        check_val("badcs_busy_cycles", busy_cnt - b0, 36);
        check_val("badcs_no_cs", cs_low_cnt - c0, 0);

`ifdef SPI_CTRL_LOOPBACK_EN
        @(negedge clk);
        lpbk = 1'b1;
        c0 = cs_low_cnt;
        send(8'h5A, 2'd0, 1'b1, 8'h5A, 1, 0);
        wait_idle();
        check_val("lpbk_no_cs", cs_low_cnt - c0, 0);
        lpbk = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check_val("rx_queue_empty", rx_exp.size(), 0);
        check_val("slave_queue_empty", slave_exp.size(), 0);
        check_val("cs_onehot", cs_multi_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
